spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 8: SPI data byte width.
REQ-002 SHALL have parameter TimeoutWidth, default 16: width of grant watchdog counter.
REQ-003 SHALL have port Clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_i, input, 1: synchronous reset, active-high.
REQ-005 SHALL have ports Req0_i / Req1_i, input, 1 each: requester wants the SPI master.
REQ-006 SHALL have ports Gnt0_o / Gnt1_o, output, 1 each: requester owns the SPI master.
REQ-007 SHALL have ports ReqN_Write_i and ReqN_ReadNext_i, input, 1 each, and ReqN_Data_i, input, DataWidth, for N in {0,1}: per-requester SPI strobes and write data.
REQ-008 SHALL have ports ReqN_FIFOFull_o, ReqN_FIFOEmpty_o and ReqN_Transmission_o, output, 1 each, for N in {0,1}: gated SPI status per requester.
REQ-009 SHALL have ports SPI_Write_o and SPI_ReadNext_o, output, 1 each, and SPI_Data_o, output, DataWidth: to SPI master.
REQ-010 SHALL have ports SPI_FIFOFull_i, SPI_FIFOEmpty_i and SPI_Transmission_i, input, 1 each: from SPI master.
REQ-011 SHALL have port Timeout_i, input, TimeoutWidth: maximum grant length in cycles; 0 = unlimited.
REQ-012 SHALL have port TimeoutIRQ_o, output, 1: one-cycle pulse on forced release.
REQ-013 SHALL have port Busy_o, output, 1: state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, GRANT0, GRANT1 and DRAIN; Gnt0_o is 1 only in GRANT0 and Gnt1_o is 1 only in GRANT1, both registered.
REQ-015 In IDLE with exactly one eligible request, the FSM SHALL enter that requester's GRANT state on the next edge (grant latency 1 cycle).
REQ-016 In IDLE with both requests eligible, the FSM SHALL grant the requester not recorded in register LastGnt (round-robin); LastGnt SHALL update on GRANT entry.
REQ-017 In GRANTn, SPI_Write_o, SPI_ReadNext_o and SPI_Data_o SHALL equal requester n's inputs combinationally; in all other states they SHALL be 0.
REQ-018 For the granted requester, FIFOFull, FIFOEmpty and Transmission outputs SHALL pass the SPI inputs through; for a non-granted requester they SHALL be forced to FIFOFull=1, FIFOEmpty=1, Transmission=0.
REQ-019 In GRANTn, deassertion of Reqn_i SHALL move the FSM to DRAIN on the next edge; strobes in that cycle are still forwarded.
REQ-020 In DRAIN, the FSM SHALL remain until SPI_Transmission_i=0 and SPI_FIFOEmpty_i=1, then enter IDLE; minimum DRAIN time is 1 cycle.
REQ-021 No requester SHALL be granted directly from DRAIN or from another GRANT state; every handover SHALL pass through IDLE.
REQ-022 Busy_o SHALL be 1 in GRANT0, GRANT1 and DRAIN.

Reset
REQ-023 When Reset_i=1 at an edge, the block SHALL enter IDLE, set LastGnt=1 (requester 0 wins the first tie), clear the watchdog and blocked flags, and drive Gnt*_o, TimeoutIRQ_o and Busy_o to 0; this applies mid-transfer too.

Configuration
REQ-024 With macro SPI_ARBITER_TIMEOUT_EN defined, a down-counter SHALL load Timeout_i on GRANT entry and decrement each cycle in GRANT.
REQ-025 With the macro defined, when the counter reaches 1 with the request still high and Timeout_i!=0, the FSM SHALL enter DRAIN and pulse TimeoutIRQ_o for 1 cycle.
REQ-026 With the macro defined, a timed-out requester SHALL be ineligible until its Req is seen low for at least 1 cycle.
REQ-027 With the macro defined, a request drop in the same cycle as expiry SHALL count as a normal release: no IRQ and no blocking.
REQ-028 Without SPI_ARBITER_TIMEOUT_EN, no counter SHALL exist, Timeout_i SHALL be ignored, TimeoutIRQ_o SHALL be tied 0, and grants SHALL be unbounded.

Verification
REQ-029 SHALL test: Req0=1 only from reset -> Gnt0=1 one cycle later; Req1 response outputs show Full=1, Empty=1, Trans=0.
REQ-030 SHALL test: Req0 and Req1 both high in IDLE after reset -> Gnt0 first; after release and drain, Gnt1.
REQ-031 SHALL test: Req0 drops while SPI_Transmission_i=1 for 5 cycles -> DRAIN is held 5 cycles, Busy_o=1, SPI_Write_o=0, then IDLE.
REQ-032 SHALL test: macro defined, Timeout_i=4, Req1 held high -> Gnt1 high for 4 cycles, TimeoutIRQ_o single pulse, no regrant to requester 1 until it toggles low.
REQ-033 SHALL test: Reset_i=1 during GRANT1 with SPI_Write active -> next cycle IDLE, all grants 0, SPI_Write_o=0.
REQ-034 SHALL test: macro undefined, Timeout_i=2, Req0 held 100 cycles -> Gnt0 stays high throughout and TimeoutIRQ_o stays 0.

Source files
------------

// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter sharing one SPI master, with drain-before-handover.
// Optional grant watchdog enabled by defining SPI_ARBITER_TIMEOUT_EN.
module spi_arbiter #(
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned TimeoutWidth = 16
) (
    input  logic                    Clk_i,
    input  logic                    Reset_i,
    input  logic                    Req0_i,
    input  logic                    Req1_i,
    output logic                    Gnt0_o,
    output logic                    Gnt1_o,
    input  logic                    Req0_Write_i,
    input  logic                    Req0_ReadNext_i,
    input  logic [DataWidth-1:0]    Req0_Data_i,
    input  logic                    Req1_Write_i,
    input  logic                    Req1_ReadNext_i,
    input  logic [DataWidth-1:0]    Req1_Data_i,
    output logic                    Req0_FIFOFull_o,
    output logic                    Req0_FIFOEmpty_o,
    output logic                    Req0_Transmission_o,
    output logic                    Req1_FIFOFull_o,
    output logic                    Req1_FIFOEmpty_o,
    output logic                    Req1_Transmission_o,
    output logic                    SPI_Write_o,
    output logic                    SPI_ReadNext_o,
    output logic [DataWidth-1:0]    SPI_Data_o,
    input  logic                    SPI_FIFOFull_i,
    input  logic                    SPI_FIFOEmpty_i,
    input  logic                    SPI_Transmission_i,
    input  logic [TimeoutWidth-1:0] Timeout_i,
    output logic                    TimeoutIRQ_o,
    output logic                    Busy_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrant0 = 2'd1;
    localparam logic [1:0] StGrant1 = 2'd2;
    localparam logic [1:0] StDrain  = 2'd3;

    logic [1:0] state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       elig0, elig1;
    logic       expire;

`ifdef SPI_ARBITER_TIMEOUT_EN
    logic [TimeoutWidth-1:0] cnt_q, cnt_d;
    logic                    irq_q, irq_d;
    logic                    blocked0_q, blocked0_d;
    logic                    blocked1_q, blocked1_d;

    // Expiry only counts while the owner still requests; a simultaneous drop is a normal release.
    assign expire = ((state_q == StGrant0 && Req0_i) || (state_q == StGrant1 && Req1_i)) &&
                    (cnt_q == TimeoutWidth'(1)) && (Timeout_i != '0);
    assign elig0  = Req0_i && !blocked0_q;
    assign elig1  = Req1_i && !blocked1_q;

    always_comb begin
        cnt_d      = cnt_q;
        irq_d      = expire;
        blocked0_d = blocked0_q;
        blocked1_d = blocked1_q;
        if (state_q == StIdle && (state_d == StGrant0 || state_d == StGrant1)) begin
            cnt_d = Timeout_i;
        end else if ((state_q == StGrant0 || state_q == StGrant1) && cnt_q != '0) begin
            cnt_d = cnt_q - TimeoutWidth'(1);
        end
        if (!Req0_i) begin
            blocked0_d = 1'b0;
        end else if (expire && state_q == StGrant0) begin
            blocked0_d = 1'b1;
        end
        if (!Req1_i) begin
            blocked1_d = 1'b0;
        end else if (expire && state_q == StGrant1) begin
            blocked1_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            blocked0_q <= 1'b0;
            blocked1_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
            blocked0_q <= blocked0_d;
            blocked1_q <= blocked1_d;
        end
    end

    assign TimeoutIRQ_o = irq_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^Timeout_i;
    assign expire         = 1'b0;
    assign elig0          = Req0_i;
    assign elig1          = Req1_i;
    assign TimeoutIRQ_o   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            StIdle: begin
                if (elig0 && (!elig1 || last_gnt_q)) begin
                    state_d    = StGrant0;
                    last_gnt_d = 1'b0;
                end else if (elig1) begin
                    state_d    = StGrant1;
                    last_gnt_d = 1'b1;
                end
            end
            StGrant0: begin
                if (!Req0_i || expire) begin
                    state_d = StDrain;
                end
            end
            StGrant1: begin
                if (!Req1_i || expire) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!SPI_Transmission_i && SPI_FIFOEmpty_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign Gnt0_o = (state_q == StGrant0);
    assign Gnt1_o = (state_q == StGrant1);
    assign Busy_o = (state_q != StIdle);

    always_comb begin
        SPI_Write_o    = 1'b0;
        SPI_ReadNext_o = 1'b0;
        SPI_Data_o     = '0;
        if (Gnt0_o) begin
            SPI_Write_o    = Req0_Write_i;
            SPI_ReadNext_o = Req0_ReadNext_i;
            SPI_Data_o     = Req0_Data_i;
        end else if (Gnt1_o) begin
            SPI_Write_o    = Req1_Write_i;
            SPI_ReadNext_o = Req1_ReadNext_i;
            SPI_Data_o     = Req1_Data_i;
        end
    end

    // Non-owners see a full, empty, idle master so they never attempt a transfer.
    assign Req0_FIFOFull_o     = Gnt0_o ? SPI_FIFOFull_i     : 1'b1;
    assign Req0_FIFOEmpty_o    = Gnt0_o ? SPI_FIFOEmpty_i    : 1'b1;
    assign Req0_Transmission_o = Gnt0_o ? SPI_Transmission_i : 1'b0;
    assign Req1_FIFOFull_o     = Gnt1_o ? SPI_FIFOFull_i     : 1'b1;
    assign Req1_FIFOEmpty_o    = Gnt1_o ? SPI_FIFOEmpty_i    : 1'b1;
    assign Req1_Transmission_o = Gnt1_o ? SPI_Transmission_i : 1'b0;

endmodule
